// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester arbiter/sequencer for the 8x9 single-ported register file
// Optional ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed sequencer priority.
module regfile_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       kp_req,
  input  logic       kp_we,
  input  logic [2:0] kp_addr,
  input  logic [8:0] kp_wdata,
  input  logic       kp_lock,
  output logic       kp_gnt,
  output logic       kp_done,
  input  logic       sq_req,
  input  logic       sq_we,
  input  logic [2:0] sq_addr,
  input  logic [8:0] sq_wdata,
  input  logic       sq_lock,
  output logic       sq_gnt,
  output logic       sq_done,
  output logic [2:0] rf_addr,
  output logic [8:0] rf_wdata,
  output logic       rf_write,
  input  logic [8:0] rf_rdata,
  output logic [8:0] rd_data,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic       l_we, l_lock, l_own;
  logic [2:0] l_addr;
  logic [8:0] l_wdata;
  logic       lk_v, lk_own;
  logic       own_req, own_lock, hold, release_lk, tie_sq, any, win_sq;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last;
`endif
  always_comb begin
    own_req    = lk_own ? sq_req : kp_req;
    own_lock   = lk_own ? sq_lock : kp_lock;
    hold       = lk_v && own_req;
    release_lk = lk_v && (!own_req || !own_lock);
`ifdef ARB_ROUND_ROBIN_EN
    tie_sq     = !last;
`else
    tie_sq     = 1'b1;
`endif
    any        = sq_req || kp_req;
    // a requesting lock owner keeps the port even on its final (lock=0) access
    win_sq     = hold ? lk_own : sq_req && (!kp_req || tie_sq);
    state_n    = state == IDLE ? (any ? ACCESS : IDLE) : state == ACCESS ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      l_we    <= 1'b0;
      l_lock  <= 1'b0;
      l_own   <= 1'b0;
      l_addr  <= 3'd0;
      l_wdata <= 9'd0;
      lk_v    <= 1'b0;
      lk_own  <= 1'b0;
      rd_data <= 9'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        l_own   <= win_sq;
        l_we    <= win_sq ? sq_we : kp_we;
        l_addr  <= win_sq ? sq_addr : kp_addr;
        l_wdata <= win_sq ? sq_wdata : kp_wdata;
        l_lock  <= win_sq ? sq_lock : kp_lock;
      end
      if (state == IDLE && release_lk) lk_v <= 1'b0;
      if (state == ACCESS) rd_data <= rf_rdata;
      if (state == DONE) begin
        if (l_lock) begin
          lk_v   <= 1'b1;
          lk_own <= l_own;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last <= l_own;
`endif
      end
    end
  end
  assign rf_addr  = l_addr;
  assign rf_wdata = l_wdata;
  assign rf_write = state == ACCESS && l_we;
  assign busy     = state != IDLE;
  assign kp_gnt   = busy && !l_own;
  assign sq_gnt   = busy && l_own;
  assign kp_done  = state == DONE && !l_own;
  assign sq_done  = state == DONE && l_own;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: table-driven and sequence checks of regfile_arbiter with an rd_data scoreboard
module tb_regfile_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       kp_req = 0, kp_we = 0, kp_lock = 0, sq_req = 0, sq_we = 0, sq_lock = 0;
  logic [2:0] kp_addr = 0, sq_addr = 0;
  logic [8:0] kp_wdata = 0, sq_wdata = 0;
  logic       kp_gnt, kp_done, sq_gnt, sq_done, rf_write, busy;
  logic [2:0] rf_addr;
  logic [8:0] rf_wdata, rf_rdata, rd_data;
  logic [8:0] mem [8] = '{default: 9'd0};
  logic [8:0] exp_q [$];
  bit         win_q [$];
  int         checks = 0, errors = 0;
  bit         kp_seen;

  regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .kp_req(kp_req), .kp_we(kp_we), .kp_addr(kp_addr), .kp_wdata(kp_wdata), .kp_lock(kp_lock),
    .kp_gnt(kp_gnt), .kp_done(kp_done),
    .sq_req(sq_req), .sq_we(sq_we), .sq_addr(sq_addr), .sq_wdata(sq_wdata), .sq_lock(sq_lock),
    .sq_gnt(sq_gnt), .sq_done(sq_done),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_write(rf_write), .rf_rdata(rf_rdata),
    .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rf_write) mem[rf_addr] <= rf_wdata;
  assign rf_rdata = mem[rf_addr];

  typedef struct {
    bit         s;
    bit         w;
    logic [2:0] a;
    logic [8:0] d;
    logic [8:0] er;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string n, input logic [8:0] a, input logic [8:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic do_reset();
    rst = 1; kp_req = 0; sq_req = 0; kp_lock = 0; sq_lock = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic do_access(input bit s, input bit w, input logic [2:0] a, input logic [8:0] d,
                           input logic [8:0] er);
    logic [8:0] e;
    if (s) begin sq_req = 1; sq_we = w; sq_addr = a; sq_wdata = d; sq_lock = 0; end
    else   begin kp_req = 1; kp_we = w; kp_addr = a; kp_wdata = d; kp_lock = 0; end
    exp_q.push_back(er);
    @(negedge clk);
    chk("gnt", s ? sq_gnt : kp_gnt, 1);
    chk("other_gnt", s ? kp_gnt : sq_gnt, 0);
    chk("rf_write", rf_write, w);
    chk("rf_addr", rf_addr, a);
    if (w) chk("rf_wdata", rf_wdata, d);
    sq_req = 0; kp_req = 0;
    @(negedge clk);
    chk("done", s ? sq_done : kp_done, 1);
    chk("other_done", s ? kp_done : sq_done, 0);
    chk("rf_write_in_done", rf_write, 0);
    e = exp_q.pop_front();
    chk("rd_data", rd_data, e);
    @(negedge clk);
    chk("idle_after", busy, 0);
  endtask

  task automatic wait_done(output bit who, output bit ok);
    ok = 0; who = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (kp_gnt) kp_seen = 1;
      chk("excl", {8'd0, (kp_gnt & sq_gnt) | (kp_done & sq_done)}, 0);
      if (kp_done || sq_done) begin ok = 1; who = sq_done; end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    bit         who, ok;
    logic [8:0] e;
    logic [2:0] la [3] = '{3'd1, 3'd2, 3'd0};
    bit         lw [3] = '{1'b0, 1'b0, 1'b1};
    bit         ll [3] = '{1'b1, 1'b1, 1'b0};
    tbl[0] = '{0, 1, 3'd3, 9'h05A, 9'h000};
    tbl[1] = '{1, 1, 3'd3, 9'h1FF, 9'h05A};
    tbl[2] = '{0, 0, 3'd3, 9'h000, 9'h1FF};
    tbl[3] = '{1, 1, 3'd7, 9'h123, 9'h000};
    tbl[4] = '{0, 1, 3'd0, 9'h0AA, 9'h000};
    tbl[5] = '{1, 0, 3'd7, 9'h000, 9'h123};
    tbl[6] = '{0, 0, 3'd0, 9'h000, 9'h0AA};
    tbl[7] = '{1, 1, 3'd1, 9'h011, 9'h000};
    tbl[8] = '{1, 1, 3'd2, 9'h022, 9'h000};
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {7'd0, kp_gnt, sq_gnt}, 0);
    chk("rst_done", {7'd0, kp_done, sq_done}, 0);
    chk("rst_rf_write", rf_write, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_rd_data", rd_data, 0);
    foreach (tbl[i]) do_access(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er);

    // both requesters held for three rounds
    do_reset();
    kp_req = 1; kp_we = 0; kp_addr = 3'd3;
    sq_req = 1; sq_we = 0; sq_addr = 3'd7;
`ifdef ARB_ROUND_ROBIN_EN
    win_q = '{1'b1, 1'b0, 1'b1};
`else
    win_q = '{1'b1, 1'b1, 1'b1};
`endif
    for (int r = 0; r < 3; r++) begin
      wait_done(who, ok);
      if (ok) chk("sim_winner", {8'd0, who}, {8'd0, win_q.pop_front()});
    end
    kp_req = 0; sq_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("sim_idle", busy, 0);

    // locked read-read-write by the sequencer while keypad waits
    do_reset();
    kp_seen = 0;
    kp_req = 1; kp_we = 0; kp_addr = 3'd3;
    sq_req = 1; sq_we = lw[0]; sq_addr = la[0]; sq_wdata = 9'h155; sq_lock = ll[0];
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h0AA);
    exp_q.push_back(9'h1FF);
    for (int k = 0; k < 3; k++) begin
      wait_done(who, ok);
      chk("lock_winner", {8'd0, who}, 1);
      e = exp_q.pop_front();
      chk("lock_rd", rd_data, e);
      if (k < 2) begin sq_we = lw[k+1]; sq_addr = la[k+1]; sq_lock = ll[k+1]; end
      else sq_req = 0;
    end
    chk("kp_gnt_during_lock", {8'd0, kp_seen}, 0);
    wait_done(who, ok);
    chk("after_lock_winner", {8'd0, who}, 0);
    e = exp_q.pop_front();
    chk("after_lock_rd", rd_data, e);
    kp_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("lock_reg0", mem[0], 9'h155);

    // request dropped during ACCESS of a write still commits
    do_access(1, 1, 3'd5, 9'h0F0, 9'h000);
    do_access(0, 0, 3'd5, 9'h000, 9'h0F0);

    // reset in the middle of a locked keypad write
    kp_req = 1; kp_we = 1; kp_addr = 3'd6; kp_wdata = 9'h033; kp_lock = 1;
    wait_done(who, ok);
    chk("kp_lock_first", {8'd0, who}, 0);
    kp_wdata = 9'h0CC;
    ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      ok = kp_gnt;
    end
    if (!ok) chk("gnt_timeout", 0, 1);
    chk("mid_rf_write", rf_write, 1);
    rst = 1; kp_req = 0;
    @(negedge clk);
    rst = 0;
    chk("mid_busy", busy, 0);
    chk("mid_rf_write_clr", rf_write, 0);
    chk("mid_no_done", {7'd0, kp_done, sq_done}, 0);
    chk("mid_gnt", {7'd0, kp_gnt, sq_gnt}, 0);
    kp_req = 1; kp_we = 0; kp_lock = 1;
    sq_req = 1; sq_we = 0; sq_addr = 3'd6; sq_lock = 0;
    exp_q.push_back(9'h0CC);
    wait_done(who, ok);
    chk("lock_cleared_winner", {8'd0, who}, 1);
    e = exp_q.pop_front();
    chk("write_stands", rd_data, e);
    kp_req = 0; sq_req = 0;
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
